// File: rtl/link_train_send_if.sv
// -----------------------------------------------------------------------------
// link_train_send_if
// Word handshake between the link-layer word source and the serial transmitter.
//
// Signals:
//   DOUT    [15:0]  current word, bit 15 first on the wire   (source -> sink)
//   DOPUSH          DOUT valid                                (source -> sink)
//   DOPULL          sink accepts the current word this cycle  (sink -> source)
//
// Modports:
//   master  word source (link_train_send)
//   slave   word sink (serial transmitter)
// -----------------------------------------------------------------------------
interface link_train_send_if;
    logic [15:0] DOUT;
    logic        DOPUSH;
    logic        DOPULL;

    modport master (
        output DOUT,
        output DOPUSH,
        input  DOPULL
    );

    modport slave (
        input  DOUT,
        input  DOPUSH,
        output DOPULL
    );
endinterface : link_train_send_if

// File: rtl/link_train_send.sv
// -----------------------------------------------------------------------------
// link_train_send
// Transmit word source for the LVDS serdes test path. After reset or CLR it
// emits TRAIN_LEN training words so the far-end word aligner can lock, then a
// PRBS-15 (x^15 + x^14 + 1) payload with optional periodic sync words.
//
// Build option:
//   LINK_TRAIN_SEND_SYNC_EN  defined   : one SYNC_WORD after every SYNC_PERIOD
//                                        PRBS words.
//                            undefined : uninterrupted PRBS payload, no
//                                        payload counter.
//
// Parameters:
//   TRAIN_LEN    training words accepted before payload (1..65535)
//   SYNC_PERIOD  PRBS words between sync words (2..65535)
//   TRAIN_WORD   training pattern word
//   SYNC_WORD    sync marker word
//
// Ports:
//   RSTXF     in   asynchronous reset, active-low
//   CLKF      in   word clock
//   CLR       in   synchronous restart of training and all counters
//   lnk       if   master side: DOUT / DOPUSH out, DOPULL in
//   PHY_INIT  out  high while training
//   SEND_CNT  out  accepted payload words (PRBS + sync), saturating
// -----------------------------------------------------------------------------
module link_train_send #(
    parameter int unsigned TRAIN_LEN   = 64,
    parameter int unsigned SYNC_PERIOD = 1024,
    parameter logic [15:0] TRAIN_WORD  = 16'hFF00,
    parameter logic [15:0] SYNC_WORD   = 16'h0FF0
) (
    input  logic                     RSTXF,
    input  logic                     CLKF,
    input  logic                     CLR,
    link_train_send_if.master        lnk,
    output logic                     PHY_INIT,
    output logic [47:0]              SEND_CNT
);

    typedef enum logic [1:0] {
        ST_TRAIN = 2'd0,   // presenting training words
        ST_DATA  = 2'd1,   // presenting a PRBS word
        ST_SYNC  = 2'd2    // presenting the sync word (part of DATA phase)
    } state_t;

    localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_LEN - 1);

    state_t      r_state;
    logic [15:0] r_train_cnt;
    logic [14:0] r_prbs;        // r_prbs[14] is the earliest pending bit
    logic [15:0] r_dout;
    logic        r_dopush;
    logic        r_phy_init;
    logic [47:0] r_send_cnt;

    logic        w_accept;
    logic        w_train_last;
    logic        w_sync_hit;
    logic [15:0] w_prbs_word;
    logic [14:0] w_prbs_adv;

    assign w_accept     = r_dopush & lnk.DOPULL;
    assign w_train_last = (r_train_cnt == TRAIN_LAST);

`ifdef LINK_TRAIN_SEND_SYNC_EN
    localparam logic [15:0] PAY_LAST = 16'(SYNC_PERIOD - 1);

    logic [15:0] r_pay_cnt;     // PRBS words accepted since the last sync

    // The PRBS word being accepted is the last one before a sync marker.
    assign w_sync_hit = (r_pay_cnt == PAY_LAST);
`else
    assign w_sync_hit = 1'b0;
`endif

    // Sixteen serial steps of a(n) = a(n-15) ^ a(n-14): the word collects the
    // bits in emission order (earliest into bit 15) and w_prbs_adv is the
    // state for the following word.
    always_comb begin : prbs_step
        logic [14:0] v_s;
        // NOTE: every variable written here gets a value before any branch or
        // loop so that no latch can be inferred.
        v_s         = r_prbs;
        w_prbs_word = '0;
        for (int i = 15; i >= 0; i--) begin
            w_prbs_word[i] = v_s[14];
            v_s            = {v_s[13:0], v_s[14] ^ v_s[13]};
        end
        w_prbs_adv = v_s;
    end

    // Single registered FSM. DOUT always holds the word on offer; an accept
    // loads the next word, so the PRBS state is one word ahead of DOUT.
    always_ff @(posedge CLKF or negedge RSTXF) begin
        // NOTE: sequential state is updated only with non-blocking assignments
        // so every register samples the pre-edge values of the others.
        if (!RSTXF) begin
            r_state     <= ST_TRAIN;
            r_train_cnt <= '0;
            r_prbs      <= '1;
            r_dout      <= '0;
            r_dopush    <= 1'b0;
            r_phy_init  <= 1'b1;
            r_send_cnt  <= '0;
`ifdef LINK_TRAIN_SEND_SYNC_EN
            r_pay_cnt   <= '0;
`endif
        end else if (CLR) begin
            // Same as reset except that the first training word is on offer.
            r_state     <= ST_TRAIN;
            r_train_cnt <= '0;
            r_prbs      <= '1;
            r_dout      <= TRAIN_WORD;
            r_dopush    <= 1'b1;
            r_phy_init  <= 1'b1;
            r_send_cnt  <= '0;
`ifdef LINK_TRAIN_SEND_SYNC_EN
            r_pay_cnt   <= '0;
`endif
        end else if (!r_dopush) begin
            // First edge after reset release: offer the first training word.
            r_dout   <= TRAIN_WORD;
            r_dopush <= 1'b1;
        end else if (w_accept) begin
            if ((r_state != ST_TRAIN) && (r_send_cnt != '1)) begin
                r_send_cnt <= r_send_cnt + 48'd1;
            end

            case (r_state)
                ST_TRAIN: begin
                    if (w_train_last) begin
                        r_state     <= ST_DATA;
                        r_phy_init  <= 1'b0;
                        r_train_cnt <= '0;
                        r_dout      <= w_prbs_word;
                        r_prbs      <= w_prbs_adv;
                    end else begin
                        r_train_cnt <= r_train_cnt + 16'd1;
                    end
                end

                ST_DATA: begin
                    if (w_sync_hit) begin
                        // Sync word does not consume PRBS bits.
                        r_state <= ST_SYNC;
                        r_dout  <= SYNC_WORD;
`ifdef LINK_TRAIN_SEND_SYNC_EN
                        r_pay_cnt <= '0;
`endif
                    end else begin
                        r_dout <= w_prbs_word;
                        r_prbs <= w_prbs_adv;
`ifdef LINK_TRAIN_SEND_SYNC_EN
                        r_pay_cnt <= r_pay_cnt + 16'd1;
`endif
                    end
                end

                ST_SYNC: begin
                    r_state <= ST_DATA;
                    r_dout  <= w_prbs_word;
                    r_prbs  <= w_prbs_adv;
                end

                default: begin
                    r_state <= ST_TRAIN;
                end
            endcase
        end
    end

    assign lnk.DOUT   = r_dout;
    assign lnk.DOPUSH = r_dopush;
    assign PHY_INIT   = r_phy_init;
    assign SEND_CNT   = r_send_cnt;

endmodule : link_train_send

// File: tb/tb_link_train_send.sv
// -----------------------------------------------------------------------------
// tb_link_train_send
// Directed bench for link_train_send with TRAIN_LEN=4, SYNC_PERIOD=4. The
// expected word stream is built from a serial PRBS-15 bit recurrence plus the
// training and (when LINK_TRAIN_SEND_SYNC_EN is defined) sync insertion rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_link_train_send;

    localparam int TL = 4;
    localparam int SP = 4;

    logic        rstxf;
    logic        clkf;
    logic        clr;
    logic        phy_init;
    logic [47:0] send_cnt;

    link_train_send_if lnk ();

    link_train_send #(
        .TRAIN_LEN   (TL),
        .SYNC_PERIOD (SP),
        .TRAIN_WORD  (16'hFF00),
        .SYNC_WORD   (16'h0FF0)
    ) dut (
        .RSTXF    (rstxf),
        .CLKF     (clkf),
        .CLR      (clr),
        .lnk      (lnk),
        .PHY_INIT (phy_init),
        .SEND_CNT (send_cnt)
    );

    initial clkf = 1'b0;
    always #5 clkf = ~clkf;

    int          n_total = 0;
    int          n_bad   = 0;
    bit          prbs_bits [4096];
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clkf);
        #1;
    endtask

    // idx = number of words accepted since training (re)started; the DUT
    // should be offering exp_q[idx].
    task automatic check_stream(input int idx, input string tag);
        check({tag, " dout"}, {48'd0, lnk.DOUT}, {48'd0, exp_q[idx]});
        check({tag, " phy_init"}, {63'd0, phy_init}, {63'd0, (idx < TL)});
        check({tag, " send_cnt"}, {16'd0, send_cnt}, (idx > TL) ? 64'(idx - TL) : 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " dout"},     {48'd0, lnk.DOUT},   64'h0);
        check({tag, " dopush"},   {63'd0, lnk.DOPUSH}, 64'h0);
        check({tag, " phy_init"}, {63'd0, phy_init},   64'h1);
        check({tag, " send_cnt"}, {16'd0, send_cnt},   64'h0);
    endtask

    initial begin
        int          idx;
        logic [15:0] w;
        logic        pull;

        // Reference stream: training words, then PRBS words (with sync words).
        for (int n = 0; n < 4096; n++)
            prbs_bits[n] = (n < 15) ? 1'b1 : (prbs_bits[n-15] ^ prbs_bits[n-14]);
        for (int t = 0; t < TL; t++) exp_q.push_back(16'hFF00);
        begin
`ifdef LINK_TRAIN_SEND_SYNC_EN
            int pc;
            pc = 0;
`endif
            for (int j = 0; j < 200; j++) begin
                for (int b = 0; b < 16; b++) w[15-b] = prbs_bits[16*j + b];
                exp_q.push_back(w);
`ifdef LINK_TRAIN_SEND_SYNC_EN
                pc++;
                if (pc == SP) begin
                    exp_q.push_back(16'h0FF0);
                    pc = 0;
                end
`endif
            end
        end

        // ---- reset state ----
        rstxf      = 1'b0;
        clr        = 1'b0;
        lnk.DOPULL = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");

        // ---- power-on stream, DOPULL held high ----
        rstxf      = 1'b1;
        lnk.DOPULL = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            check_stream(k, "run");
            if (k == 0)      check("run first dopush", {63'd0, lnk.DOPUSH}, 64'h1);
            if (k == TL)     check("run prbs word1", {48'd0, lnk.DOUT}, 64'hFFFE);
            if (k == TL + 1) check("run prbs word2", {48'd0, lnk.DOUT}, 64'h0004);
            if (k == TL + 2) check("run send_cnt 2", {16'd0, send_cnt}, 64'd2);
`ifdef LINK_TRAIN_SEND_SYNC_EN
            if (k == TL + SP) check("run sync word", {48'd0, lnk.DOUT}, 64'h0FF0);
`endif
        end

        // ---- pseudo-random DOPULL through training and payload ----
        rstxf = 1'b0;
        tick();
        rstxf = 1'b1;
        tick();
        idx = 0;
        check_stream(idx, "rnd start");
        for (int c = 0; c < 120; c++) begin
            pull       = 1'($urandom_range(0, 1));
            lnk.DOPULL = pull;
            tick();
            if (pull) idx++;
            check_stream(idx, "rnd");
        end

        // ---- CLR mid-payload with SEND_CNT = 100 ----
        rstxf      = 1'b0;
        tick();
        rstxf      = 1'b1;
        lnk.DOPULL = 1'b1;
        tick();
        for (idx = 0; idx < TL + 100; idx++) tick();
        check("clr pre send_cnt", {16'd0, send_cnt}, 64'd100);
        clr        = 1'b1;
        lnk.DOPULL = 1'b0;   // CLR must act regardless of DOPULL
        tick();
        check("clr dout",     {48'd0, lnk.DOUT},   64'hFF00);
        check("clr phy_init", {63'd0, phy_init},   64'h1);
        check("clr send_cnt", {16'd0, send_cnt},   64'h0);
        check("clr dopush",   {63'd0, lnk.DOPUSH}, 64'h1);
        lnk.DOPULL = 1'b1;   // held CLR keeps training from counting
        tick();
        check("clr hold dout", {48'd0, lnk.DOUT}, 64'hFF00);
        check("clr hold cnt",  {16'd0, send_cnt}, 64'h0);
        clr = 1'b0;
        for (int k = 1; k <= TL + 2; k++) begin
            tick();
            check_stream(k, "clr");
            if (k == TL) check("clr first prbs", {48'd0, lnk.DOUT}, 64'hFFFE);
        end

        // ---- asynchronous reset mid-payload ----
        #3;
        rstxf = 1'b0;
        #1;
        check_reset_vals("async rst");
        tick();
        rstxf = 1'b1;
        for (int k = 0; k < TL + 8; k++) begin
            tick();
            check_stream(k, "por2");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_link_train_send

// File: doc/link_train_send.md
# link_train_send

Link-layer transmit word source for the LVDS serdes test path, clocked on CLKF. It first emits a fixed training word so the far-end word aligner can lock. It then emits a PRBS-15 payload with periodic sync words that the far-end checker can compare. Output words (DOUT, 16 bits, bit 15 first on the wire) feed the serial transmitter. PHY_INIT tells the local receive path that training is in progress.

## Interface
- TRAIN_LEN, 64: number of accepted training words before payload (legal 1..65535).
- SYNC_PERIOD, 1024: payload words between sync words (legal 2..65535).
- TRAIN_WORD, 16'hFF00: training pattern word.
- SYNC_WORD, 16'h0FF0: sync marker word.
- RSTXF  input  1  asynchronous reset, active-low.
- CLKF  input  1  word clock; all logic rises on CLKF.
- CLR  input  1  synchronous restart of training and counters.
- DOPULL  input  1  downstream accepts the current word this cycle.
- DOUT  output  16  current word.
- DOPUSH  output  1  DOUT valid.
- PHY_INIT  output  1  high while in TRAIN.
- SEND_CNT  output  48  accepted payload words (PRBS and sync), saturating.

## Operation
- Reset RSTXF, asynchronous, active-low; clock CLKF.
- All outputs are registered. A word transfers on a cycle with DOPUSH && DOPULL (called "accept" below).
- When DOPULL is low, DOUT, DOPUSH, state and all counters hold.
- States:
  - TRAIN: DOUT = TRAIN_WORD, PHY_INIT = 1. Train counter counts accepts. On the accept of word TRAIN_LEN the block goes to DATA.
  - DATA: PHY_INIT = 0. Emits PRBS words. Payload counter counts PRBS accepts. After SYNC_PERIOD PRBS words, one SYNC_WORD is emitted and the payload counter returns to 0. The PRBS generator does not advance on a sync word.
- PRBS:
  - Polynomial x^15+x^14+1, serial recurrence a(n) = a(n-15) xor a(n-14).
  - Seed: a(0..14) all ones.
  - Each word carries 16 consecutive bits, earliest bit in DOUT[15]. The generator advances 16 steps per accepted PRBS word.
  - First word 16'hFFFE, second 16'h0004.
- SEND_CNT increments on every accept in DATA and saturates at 48'hFFFF_FFFF_FFFF.
- CLR is synchronous and overrides DOPULL and everything else. On the next edge: state TRAIN, train and payload counters 0, PRBS reseeded, SEND_CNT 0, DOUT = TRAIN_WORD, DOPUSH = 1, PHY_INIT = 1.
- CLR held high keeps the block in that state. Training restarts counting on the first edge with CLR low.

## Timing
- Reset values: DOUT 16'h0000, DOPUSH 0, PHY_INIT 1, SEND_CNT 0, state TRAIN, PRBS seeded.
- First edge after RSTXF deasserts: DOPUSH = 1, DOUT = TRAIN_WORD. DOPUSH stays 1 from then on.
- Latency: one edge from accept to the next word on DOUT. With DOPULL held high, one word per cycle.
- Training to payload: the edge that accepts training word TRAIN_LEN also presents 16'hFFFE on DOUT and drops PHY_INIT.
- With DOPULL held high, PHY_INIT is high for TRAIN_LEN+1 cycles after reset release; this includes the DOPUSH=0 reset cycle.
- Sync: the edge accepting PRBS word SYNC_PERIOD presents SYNC_WORD. The edge accepting SYNC_WORD presents PRBS word SYNC_PERIOD+1.
- DOPULL low on the final training word or final PRBS word before sync: no transition until that word is accepted.
- Reset mid-operation: immediate return to reset values; asynchronous assert, synchronous-release behaviour as above.

## Configuration
- LINK_TRAIN_SEND_SYNC_EN:
  - Defined: sync insertion as described.
  - Undefined: DATA emits an uninterrupted PRBS stream. SYNC_WORD and SYNC_PERIOD are ignored, and the payload counter logic is removed.
  - PRBS sequence, SEND_CNT and training behaviour are identical either way.

## Test plan
- Reset release, DOPULL=1, TRAIN_LEN=4 -> DOUT 16'hFF00 for 4 cycles with PHY_INIT=1, then 16'hFFFE, 16'h0004 with PHY_INIT=0; SEND_CNT = 2 after those two accepts.
- Sync path (macro defined), SYNC_PERIOD=4 -> PRBS words 1..4, then 16'h0FF0, then PRBS word 5 (bit-identical to word 5 of a sync-free run). SEND_CNT increments for the sync word.
- DOPULL toggled pseudo-randomly through training and payload -> the accepted-word sequence equals the DOPULL=1 sequence, and DOUT is stable whenever DOPULL=0.
- CLR pulsed for 1 cycle mid-payload with SEND_CNT=100 -> next edge DOUT=16'hFF00, PHY_INIT=1, SEND_CNT=0; the first payload word after retraining is 16'hFFFE.
- RSTXF asserted mid-payload, asynchronously off-edge -> outputs go to reset values without waiting for CLKF. Release gives the same sequence as power-on.
- Macro undefined, SYNC_PERIOD=4 -> 16'h0FF0 never appears, and 20 consecutive words match the reference PRBS-15 model.
